// File: rtl/issue_mul_fifo_pkg.sv
// issue_mul_fifo_pkg
//   Shared types for the issue -> execute_mul buffer.
//   issue_execute_pack_t : entry handed from issue to execute_mul.
//   issue_mul_fifo_ptr_t : read/write pointer type (index bits plus one wrap bit),
//                          sized from ISSUE_MUL_FIFO_DEPTH.
package issue_mul_fifo_pkg;

    typedef struct packed {
        logic        enable;
        logic [5:0]  rob_id;
        logic [3:0]  uop;
        logic [31:0] src1;
        logic [31:0] src2;
    } issue_execute_pack_t;

    localparam int ISSUE_MUL_FIFO_DEPTH = 4;
    localparam int ISSUE_MUL_FIFO_PTR_W = $clog2(ISSUE_MUL_FIFO_DEPTH) + 1;

    typedef logic [ISSUE_MUL_FIFO_PTR_W-1:0] issue_mul_fifo_ptr_t;

endpackage

// File: rtl/issue_mul_fifo_if.sv
// issue_mul_fifo_if
//   Bundles the buffer's enqueue, dequeue, flush and status signals.
//   master : issue / execute_mul / commit side (drives data_in, push, pop, flush)
//   slave  : the FIFO itself (drives full, almost_full, count, data_out, data_out_valid)
//   Handshake: an entry moves on a rising edge when push && !full (enqueue) or
//   pop && data_out_valid (dequeue); flush overrides both in the same cycle.
interface issue_mul_fifo_if
    import issue_mul_fifo_pkg::*;
#(
    parameter int DEPTH = ISSUE_MUL_FIFO_DEPTH
);
    issue_execute_pack_t     issue_mul_fifo_data_in;
    logic                    issue_mul_fifo_push;
    logic                    issue_mul_fifo_full;
    logic                    issue_mul_fifo_almost_full;
    logic [$clog2(DEPTH):0]  issue_mul_fifo_count;
    issue_execute_pack_t     issue_mul_fifo_data_out;
    logic                    issue_mul_fifo_data_out_valid;
    logic                    issue_mul_fifo_pop;
    logic                    issue_mul_fifo_flush;

    modport master (
        output issue_mul_fifo_data_in, issue_mul_fifo_push,
               issue_mul_fifo_pop, issue_mul_fifo_flush,
        input  issue_mul_fifo_full, issue_mul_fifo_almost_full, issue_mul_fifo_count,
               issue_mul_fifo_data_out, issue_mul_fifo_data_out_valid
    );

    modport slave (
        input  issue_mul_fifo_data_in, issue_mul_fifo_push,
               issue_mul_fifo_pop, issue_mul_fifo_flush,
        output issue_mul_fifo_full, issue_mul_fifo_almost_full, issue_mul_fifo_count,
               issue_mul_fifo_data_out, issue_mul_fifo_data_out_valid
    );
endinterface

// File: rtl/issue_mul_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
//   Owns the read/write pointers of issue_mul_fifo and derives empty, full,
//   almost_full and occupancy from them. Flush and reset return both pointers to 0.
//   Ports: clk, rst (async, active-low), push, pop, flush in;
//          wr_en, wr_idx, rd_idx, empty, full, almost_full, count out.
module fifo_ptr_ctrl #(
    parameter int DEPTH          = 4,
    parameter int ALMOST_FULL_TH = DEPTH - 1,
    localparam int IW            = $clog2(DEPTH),
    localparam int PW            = IW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic [IW-1:0] rd_idx,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [PW-1:0] count
);
    localparam logic [PW-1:0] TH = PW'(ALMOST_FULL_TH);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty       = (wptr == rptr);
    assign full        = (wptr[IW-1:0] == rptr[IW-1:0]) && (wptr[IW] != rptr[IW]);
    assign count       = wptr - rptr;   // wraps naturally modulo 2^PW
    assign almost_full = (count >= TH);

    // full/empty are registered-state decisions: no pop look-through on full,
    // and a push into an empty buffer is never popped in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign wr_en   = push_ok && !flush;
    assign wr_idx  = wptr[IW-1:0];
    assign rd_idx  = rptr[IW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
        end
    end
endmodule

// File: rtl/issue_mul_fifo.sv
// issue_mul_fifo
//   In-order first-word-fall-through buffer between issue and execute_mul.
//   The head entry is presented combinationally; execute_mul pops it in the
//   cycle it consumes it. A commit flush discards all entries.
//   Ports: clk, rst (async, active-low), fifo (issue_mul_fifo_if.slave).
//   Optional build macro ISSUE_MUL_FIFO_CHECK_EN adds protocol assertions and a
//   sticky protocol_error register; behaviour is otherwise identical.
module issue_mul_fifo
    import issue_mul_fifo_pkg::*;
#(
    parameter int DEPTH          = ISSUE_MUL_FIFO_DEPTH,
    parameter int ALMOST_FULL_TH = DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst,
    issue_mul_fifo_if.slave    fifo
);
    localparam int IW = $clog2(DEPTH);

    issue_execute_pack_t mem [DEPTH];

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          empty;

    fifo_ptr_ctrl #(
        .DEPTH          (DEPTH),
        .ALMOST_FULL_TH (ALMOST_FULL_TH)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo.issue_mul_fifo_push),
        .pop         (fifo.issue_mul_fifo_pop),
        .flush       (fifo.issue_mul_fifo_flush),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .empty       (empty),
        .full        (fifo.issue_mul_fifo_full),
        .almost_full (fifo.issue_mul_fifo_almost_full),
        .count       (fifo.issue_mul_fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= fifo.issue_mul_fifo_data_in;
        end
    end

    // Stale storage after a flush is hidden by the empty gate.
    assign fifo.issue_mul_fifo_data_out       = empty ? '0 : mem[rd_idx];
    assign fifo.issue_mul_fifo_data_out_valid = !empty;

`ifdef ISSUE_MUL_FIFO_CHECK_EN
    logic protocol_error;
    logic bad_push;
    logic bad_pop;
    logic bad_flush;

    assign bad_push  = fifo.issue_mul_fifo_push && fifo.issue_mul_fifo_full;
    assign bad_pop   = fifo.issue_mul_fifo_pop && empty;
    assign bad_flush = fifo.issue_mul_fifo_flush &&
                       (fifo.issue_mul_fifo_push || fifo.issue_mul_fifo_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                protocol_error <= 1'b0;
        else if (bad_push || bad_pop || bad_flush) protocol_error <= 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!bad_push)  else $error("issue_mul_fifo: push while full");
            assert (!bad_pop)   else $error("issue_mul_fifo: pop while empty");
            assert (!bad_flush) else $error("issue_mul_fifo: push/pop with flush");
        end
    end
`endif
endmodule

// File: tb/tb_issue_mul_fifo.sv
module tb_issue_mul_fifo;
    import issue_mul_fifo_pkg::*;

    localparam int W = $bits(issue_execute_pack_t);

    logic clk;
    logic rst;

    issue_mul_fifo_if #(.DEPTH(4)) bus ();

    issue_mul_fifo #(.DEPTH(4), .ALMOST_FULL_TH(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_check = 0;

    function automatic issue_execute_pack_t mk(input int rob);
        issue_execute_pack_t p;
        p.enable = 1'b1;
        p.rob_id = 6'(rob);
        p.uop    = 4'(rob);
        p.src1   = 32'h1000_0000 + 32'(rob);
        p.src2   = 32'hA5A5_0000 ^ 32'(rob * 3);
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a dequeue happens at the next edge when pop && valid && !flush.
    always @(negedge clk) begin
        if (rst && bus.issue_mul_fifo_pop && bus.issue_mul_fifo_data_out_valid
            && !bus.issue_mul_fifo_flush) begin
            if (exp_q.size() == 0) begin
                n_check++;
                $display("FAIL pop_unexpected: got rob_id %0d expected no entry",
                         bus.issue_mul_fifo_data_out.rob_id);
            end else begin
                chk("pop_data", 128'(bus.issue_mul_fifo_data_out), 128'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle: inputs applied after the previous edge, released #1 after this edge.
    task automatic step(input bit p, input bit q, input bit f, input int rob, input bit accept);
        bus.issue_mul_fifo_push    = p;
        bus.issue_mul_fifo_pop     = q;
        bus.issue_mul_fifo_flush   = f;
        bus.issue_mul_fifo_data_in = mk(rob);
        if (accept) exp_q.push_back(W'(mk(rob)));
        @(posedge clk);
        #1;
        bus.issue_mul_fifo_push    = 1'b0;
        bus.issue_mul_fifo_pop     = 1'b0;
        bus.issue_mul_fifo_flush   = 1'b0;
        bus.issue_mul_fifo_data_in = '0;
    endtask

    task automatic chk_flags(input string tag, input int cnt, input bit fl, input bit af, input bit vl);
        chk({tag, "_count"}, 128'(bus.issue_mul_fifo_count), 128'(cnt));
        chk({tag, "_full"}, 128'(bus.issue_mul_fifo_full), 128'(fl));
        chk({tag, "_almost_full"}, 128'(bus.issue_mul_fifo_almost_full), 128'(af));
        chk({tag, "_valid"}, 128'(bus.issue_mul_fifo_data_out_valid), 128'(vl));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        bus.issue_mul_fifo_push    = 1'b0;
        bus.issue_mul_fifo_pop     = 1'b0;
        bus.issue_mul_fifo_flush   = 1'b0;
        bus.issue_mul_fifo_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_flags("reset", 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_flags("post_reset", 0, 0, 0, 0);
        chk("post_reset_enable", 128'(bus.issue_mul_fifo_data_out.enable), 128'(0));

        // Fill to full, threshold crossing at 3.
        for (int i = 1; i <= 3; i++) step(1, 0, 0, i, 1);
        chk_flags("three", 3, 0, 1, 1);
        step(1, 0, 0, 4, 1);
        chk_flags("full", 4, 1, 1, 1);
        chk("full_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(1));
        step(1, 0, 0, 5, 0);                       // dropped
        chk_flags("drop", 4, 1, 1, 1);
        chk("drop_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(1));

        // Drain 1..4 (checked by monitor), then over-pop.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk_flags("drained", 0, 0, 0, 0);
        chk("drained_data", 128'(bus.issue_mul_fifo_data_out), 128'(0));
        step(0, 1, 0, 0, 0);
        chk_flags("overpop", 0, 0, 0, 0);

        // Push+pop on empty: pop ignored.
        step(1, 1, 0, 7, 1);
        chk_flags("pp_empty", 1, 0, 0, 1);
        chk("pp_empty_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(7));

        // Build steady state holding 8,9.
        step(0, 1, 0, 0, 0);                       // pops 7
        step(1, 0, 0, 8, 1);
        step(1, 0, 0, 9, 1);
        chk_flags("steady0", 2, 0, 0, 1);
        for (int i = 10; i <= 19; i++) step(1, 1, 0, i, 1);   // pops 8..17
        chk_flags("steady", 2, 0, 0, 1);
        chk("steady_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(18));

        // Flush with push and pop at count 3.
        step(1, 0, 0, 20, 1);
        chk_flags("pre_flush", 3, 0, 1, 1);
        step(1, 1, 1, 21, 0);
        exp_q.delete();
        chk_flags("flush", 0, 0, 0, 0);
        chk("flush_data", 128'(bus.issue_mul_fifo_data_out), 128'(0));
        step(1, 0, 0, 30, 1);
        chk_flags("after_flush", 1, 0, 0, 1);
        chk("after_flush_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(30));
        step(0, 1, 0, 0, 0);                       // pops 30

        // Asynchronous reset mid-operation, no edge needed.
        step(1, 0, 0, 31, 0);
        step(1, 0, 0, 32, 0);
        chk_flags("pre_async", 2, 0, 0, 1);
        #2 rst = 1'b0;
        #1;
        chk_flags("async_reset", 0, 0, 0, 0);
        chk("async_reset_data", 128'(bus.issue_mul_fifo_data_out), 128'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        step(1, 0, 0, 33, 1);
        chk("post_async_head", 128'(bus.issue_mul_fifo_data_out.rob_id), 128'(33));
        step(0, 1, 0, 0, 0);                       // pops 33
        @(posedge clk);
        #1;
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule
